ps2_command_assembler: RTL and testbench

- Controller that sequences the keyboard-to-command datapath.
- Consumes one-cycle PS/2 scan-code strobes from the PS2 interface and discards break and extended sequences.
- Maps make codes to ASCII and fills a command word right-to-left. Handles backspace and enter.
- Hands completed words to the processor over a valid/ready handshake. Sits between the PS2 interface and the processor.

---
 rtl/ps2_command_assembler_pkg.sv | 28 ++
 rtl/ps2_command_assembler_scan_to_ascii.sv | 50 +++++
 rtl/ps2_command_assembler.sv | 132 +++++++++++++
 tb/tb_ps2_command_assembler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ps2_command_assembler_pkg.sv
// Shared constants and enumerations for the PS/2 keyboard-to-command datapath.
package ps2_command_assembler_pkg;

    localparam logic [7:0] SC_BREAK       = 8'hF0;
    localparam logic [7:0] SC_EXT         = 8'hE0;
    localparam logic [7:0] SC_KP_ENTER    = 8'h5A;
    localparam logic [7:0] ENTER_CODE_DEF = 8'h5A;
    localparam logic [7:0] BKSP_CODE_DEF  = 8'h66;

    typedef enum logic {
        COLLECT,
        HOLD
    } state_e;

    typedef enum logic [1:0] {
        PFX_NONE,
        PFX_BREAK,
        PFX_EXT
    } prefix_e;

    typedef enum logic [1:0] {
        KC_NONE,
        KC_CHAR,
        KC_BKSP,
        KC_ENTER
    } key_class_e;

endpackage

// File: rtl/ps2_command_assembler_scan_to_ascii.sv
// Combinational PS/2 set-2 make code to ASCII; letters and digits only, else 8'h00.
module ps2_command_assembler_scan_to_ascii (
    input  logic [7:0] scan_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        case (scan_i)
            8'h1C: ascii_o = 8'h41;
            8'h32: ascii_o = 8'h42;
            8'h21: ascii_o = 8'h43;
            8'h23: ascii_o = 8'h44;
            8'h24: ascii_o = 8'h45;
            8'h2B: ascii_o = 8'h46;
            8'h34: ascii_o = 8'h47;
            8'h33: ascii_o = 8'h48;
            8'h43: ascii_o = 8'h49;
            8'h3B: ascii_o = 8'h4A;
            8'h42: ascii_o = 8'h4B;
            8'h4B: ascii_o = 8'h4C;
            8'h3A: ascii_o = 8'h4D;
            8'h31: ascii_o = 8'h4E;
            8'h44: ascii_o = 8'h4F;
            8'h4D: ascii_o = 8'h50;
            8'h15: ascii_o = 8'h51;
            8'h2D: ascii_o = 8'h52;
            8'h1B: ascii_o = 8'h53;
            8'h2C: ascii_o = 8'h54;
            8'h3C: ascii_o = 8'h55;
            8'h2A: ascii_o = 8'h56;
            8'h1D: ascii_o = 8'h57;
            8'h22: ascii_o = 8'h58;
            8'h35: ascii_o = 8'h59;
            8'h1A: ascii_o = 8'h5A;
            8'h45: ascii_o = 8'h30;
            8'h16: ascii_o = 8'h31;
            8'h1E: ascii_o = 8'h32;
            8'h26: ascii_o = 8'h33;
            8'h25: ascii_o = 8'h34;
            8'h2E: ascii_o = 8'h35;
            8'h36: ascii_o = 8'h36;
            8'h3D: ascii_o = 8'h37;
            8'h3E: ascii_o = 8'h38;
            8'h46: ascii_o = 8'h39;
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_command_assembler.sv
// Assembles PS/2 make codes into a command word and hands it off over valid/ready.
module ps2_command_assembler
    import ps2_command_assembler_pkg::*;
#(
    parameter int unsigned MAX_CHARS  = 4,
    parameter logic [7:0]  ENTER_CODE = ENTER_CODE_DEF,
    parameter logic [7:0]  BKSP_CODE  = BKSP_CODE_DEF
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   key_valid,
    input  logic [7:0]             key_data,
    output logic [8*MAX_CHARS-1:0] cmd_word,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [2:0]             char_count,
    output logic                   overflow
);

    localparam int unsigned WORD_W  = 8 * MAX_CHARS;
    localparam logic [2:0]  MAX_CNT = 3'(MAX_CHARS);

    state_e            state_q, state_d;
    prefix_e           prefix_q, prefix_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [2:0]        count_q, count_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    key_class_e        kclass;
    logic [7:0]        ascii;

    ps2_command_assembler_scan_to_ascii u_scan_to_ascii (
        .scan_i  (key_data),
        .ascii_o (ascii)
    );

    // Prefix tracking and make-code classification; runs regardless of FSM state.
    always_comb begin
        prefix_d = prefix_q;
        kclass   = KC_NONE;
        if (key_valid) begin
            if (key_data == SC_BREAK) begin
                prefix_d = PFX_BREAK;
            end else if (key_data == SC_EXT) begin
                prefix_d = PFX_EXT;
            end else begin
                prefix_d = PFX_NONE;
                case (prefix_q)
                    PFX_NONE: begin
                        if (key_data == ENTER_CODE)     kclass = KC_ENTER;
                        else if (key_data == BKSP_CODE) kclass = KC_BKSP;
                        else if (ascii != 8'h00)        kclass = KC_CHAR;
                    end
                    PFX_EXT: begin
                        if (key_data == SC_KP_ENTER) kclass = KC_ENTER;
                    end
                    default: kclass = KC_NONE;
                endcase
            end
        end
    end

    // Word assembly FSM; HOLD freezes the word until the consumer takes it.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        count_d = count_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        case (state_q)
            COLLECT: begin
                case (kclass)
                    KC_CHAR: begin
                        if (count_q < MAX_CNT) begin
                            word_d  = {word_q[WORD_W-9:0], ascii};
                            count_d = count_q + 3'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    KC_BKSP: begin
                        if (count_q != 3'd0) begin
                            word_d  = word_q >> 8;
                            count_d = count_q - 3'd1;
                        end
                    end
                    KC_ENTER: begin
                        if (count_q != 3'd0) begin
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end
                    end
                    default: ;
                endcase
            end
            HOLD: begin
                if (cmd_ready) begin
                    word_d  = '0;
                    count_d = 3'd0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= COLLECT;
            prefix_q <= PFX_NONE;
            word_q   <= '0;
            count_q  <= 3'd0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prefix_q <= prefix_d;
            word_q   <= word_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cmd_word   = word_q;
    assign cmd_valid  = valid_q;
    assign char_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_command_assembler.sv
// Directed bench with a scoreboard of expected submitted words checked on each cmd_valid rise.
module tb_ps2_command_assembler;

    logic        clock;
    logic        resetn;
    logic        key_valid;
    logic [7:0]  key_data;
    logic [31:0] cmd_word;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  char_count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  count;
    } sub_t;

    sub_t exp_q[$];

    ps2_command_assembler dut (
        .clock      (clock),
        .resetn     (resetn),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .cmd_word   (cmd_word),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .char_count (char_count),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        key_data  = b;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic [31:0] w, input logic [2:0] c,
                                input logic v, input logic o);
        check({name, ".word"},  cmd_word, w);
        check({name, ".count"}, 32'(char_count), 32'(c));
        check({name, ".valid"}, 32'(cmd_valid), 32'(v));
        check({name, ".ovf"},   32'(overflow), 32'(o));
    endtask

    // Submit with cmd_ready held high: one-cycle valid, then everything cleared.
    task automatic submit_and_clear(input string name, input logic [31:0] w, input logic [2:0] c);
        sub_t s;
        s.word = w;
        s.count = c;
        exp_q.push_back(s);
        cmd_ready = 1'b1;
        send(8'h5A);
        check({name, ".hs_valid"}, 32'(cmd_valid), 32'd1);
        @(negedge clock);
        expect_state({name, ".cleared"}, 32'h0, 3'd0, 1'b0, 1'b0);
        cmd_ready = 1'b0;
    endtask

    // Monitor: every rising cmd_valid must match the oldest expected submission.
    initial begin
        logic prev_valid;
        sub_t s;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (cmd_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb.unexpected: got word 0x%08h with no submission expected", cmd_word);
                end else begin
                    s = exp_q.pop_front();
                    check("sb.word", cmd_word, s.word);
                    check("sb.count", 32'(char_count), 32'(s.count));
                end
            end
            prev_valid = cmd_valid;
        end
    end

    initial begin
        resetn    = 1'b0;
        key_valid = 1'b0;
        key_data  = 8'h00;
        cmd_ready = 1'b0;
        repeat (3) @(negedge clock);
        expect_state("reset", 32'h0, 3'd0, 1'b0, 1'b0);
        resetn = 1'b1;

        send(8'h1C); send(8'h32); send(8'h21);
        expect_state("abc", 32'h0041_4243, 3'd3, 1'b0, 1'b0);
        submit_and_clear("abc", 32'h0041_4243, 3'd3);

        send(8'h1C); send(8'hF0); send(8'h1C); send(8'h32);
        expect_state("break", 32'h0000_4142, 3'd2, 1'b0, 1'b0);
        submit_and_clear("break", 32'h0000_4142, 3'd2);

        send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
        expect_state("ovf", 32'h3132_3334, 3'd4, 1'b0, 1'b1);
        submit_and_clear("ovf", 32'h3132_3334, 3'd4);

        send(8'h1C); send(8'h32); send(8'h66);
        expect_state("bksp1", 32'h0000_0041, 3'd1, 1'b0, 1'b0);
        send(8'h66);
        expect_state("bksp2", 32'h0, 3'd0, 1'b0, 1'b0);
        send(8'h66);
        expect_state("bksp3", 32'h0, 3'd0, 1'b0, 1'b0);

        // Extended non-enter make ignored; typematic repeats append.
        send(8'hE0); send(8'h1C); send(8'h1C); send(8'h1C);
        expect_state("ext_rep", 32'h0000_4141, 3'd2, 1'b0, 1'b0);
        submit_and_clear("ext_rep", 32'h0000_4141, 3'd2);

        begin
            sub_t s;
            s.word = 32'h41;
            s.count = 3'd1;
            exp_q.push_back(s);
        end
        send(8'h1C); send(8'hE0); send(8'h5A);
        expect_state("kp_enter", 32'h0000_0041, 3'd1, 1'b1, 1'b0);
        send(8'h32);
        expect_state("hold_key", 32'h0000_0041, 3'd1, 1'b1, 1'b0);
        @(negedge clock);
        key_data  = 8'hF0;
        key_valid = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
        cmd_ready = 1'b0;
        expect_state("hs_f0", 32'h0, 3'd0, 1'b0, 1'b0);
        send(8'h5A);
        repeat (2) @(negedge clock);
        expect_state("post_break", 32'h0, 3'd0, 1'b0, 1'b0);

        begin
            sub_t s;
            s.word = 32'h41;
            s.count = 3'd1;
            exp_q.push_back(s);
        end
        send(8'h1C); send(8'h5A);
        expect_state("hold2", 32'h0000_0041, 3'd1, 1'b1, 1'b0);
        #2 resetn = 1'b0;
        #1 expect_state("async_rst", 32'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        send(8'h5A);
        repeat (2) @(negedge clock);
        expect_state("enter_empty", 32'h0, 3'd0, 1'b0, 1'b0);

        check("sb.drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
